// File: rtl/rtc_bus_sched.sv
// ---------------------------------------------------------------------------
// rtc_bus_sched
//
// Purpose:
//   Arbitrates between a read requester (register-sweep reader) and a write
//   requester (configuration path) for the external RTC's multiplexed
//   address/data bus. It runs each grant as one fixed-timing bus transaction:
//   ADDR -> GAP -> DATA -> RECOV, each PH_CYC clocks long. It also returns a
//   one-cycle ack and, for reads, the captured data byte.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_rd_req    read request (level, held until o_rd_ack)
//   i_rd_addr   read address, captured at grant
//   o_rd_ack    one-cycle pulse, read complete
//   o_rd_data   last byte read, valid from o_rd_ack until the next read ack
//   i_wr_req    write request (level, held until o_wr_ack)
//   i_wr_addr   write address, captured at grant
//   i_wr_data   write data, captured at grant
//   o_wr_ack    one-cycle pulse, write complete
//   o_busy      high whenever the scheduler is not idle
//   o_ad_out    value driven onto the AD bus
//   o_ad_oe     AD bus output enable
//   i_ad_in     AD bus input value
//   o_cs_n      RTC chip select, active-low
//   o_rd_n      RTC read strobe, active-low
//   o_wr_n      RTC write strobe, active-low
//   o_ad_sel    RTC A/D select: 0 = address phase, 1 = data phase
//
// All outputs are registered. Each output register loads the value that
// belongs to the state being entered, so the bus pins change on the same
// edge as the state register.
// ---------------------------------------------------------------------------
module rtc_bus_sched #(
    parameter int unsigned PH_CYC = 4,   // clocks per bus phase, 2..15
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8    // equals ADDR_W (multiplexed bus)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_ad_out,
    output logic              o_ad_oe,
    input  logic [DATA_W-1:0] i_ad_in,
    output logic              o_cs_n,
    output logic              o_rd_n,
    output logic              o_wr_n,
    output logic              o_ad_sel
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_GAP   = 3'd2,
        ST_DATA  = 3'd3,
        ST_RECOV = 3'd4
    } state_t;

    localparam logic       OP_READ  = 1'b0;
    localparam logic       OP_WRITE = 1'b1;
    localparam logic [3:0] PH_LAST  = 4'(PH_CYC - 1);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_last_grant;

    state_t              w_nxt_state;
    logic                w_ph_last;
    logic                w_gnt_rd;
    logic                w_gnt_wr;
    logic                w_grant;
    logic                w_op_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_cs_n;
    logic                w_rd_n;
    logic                w_wr_n;
    logic                w_ad_sel;
    logic                w_ad_oe;
    logic [DATA_W-1:0]   w_ad_out;
    logic                w_rd_ack;
    logic                w_wr_ack;
    logic                w_rd_cap;
    logic                w_busy;

    // Arbitration, next-state and next-output decode.
    always_comb begin
        w_nxt_state = r_state;
        w_ph_last   = (r_cnt == PH_LAST);

        // With both requests pending, the side not served last time wins.
        w_gnt_rd = i_rd_req & (~i_wr_req | (r_last_grant == OP_WRITE));
        w_gnt_wr = i_wr_req & (~i_rd_req | (r_last_grant == OP_READ));
        w_grant  = (r_state == ST_IDLE) & (w_gnt_rd | w_gnt_wr);

        // At grant, the new request's fields go straight to the output regs.
        if (w_grant) begin
            w_op_nxt   = w_gnt_wr ? OP_WRITE : OP_READ;
            w_addr_nxt = w_gnt_wr ? i_wr_addr : i_rd_addr;
            w_data_nxt = w_gnt_wr ? i_wr_data : r_data;
        end else begin
            w_op_nxt   = r_op;
            w_addr_nxt = r_addr;
            w_data_nxt = r_data;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_nxt_state = ST_ADDR;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_ph_last) begin
                    w_nxt_state = ST_GAP;
                end else begin
                    w_nxt_state = ST_ADDR;
                end
            end
            ST_GAP: begin
                if (w_ph_last) begin
                    w_nxt_state = ST_DATA;
                end else begin
                    w_nxt_state = ST_GAP;
                end
            end
            ST_DATA: begin
                if (w_ph_last) begin
                    w_nxt_state = ST_RECOV;
                end else begin
                    w_nxt_state = ST_DATA;
                end
            end
            ST_RECOV: begin
                if (w_ph_last) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_state = ST_RECOV;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase

        // Bus pin values for the state being entered.
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_ad_sel = 1'b0;
        w_ad_oe  = 1'b0;
        w_ad_out = '0;
        case (w_nxt_state)
            ST_ADDR: begin
                // The address is latched by the RTC on the write strobe.
                w_cs_n   = 1'b0;
                w_wr_n   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr_nxt;
            end
            ST_DATA: begin
                w_cs_n   = 1'b0;
                w_ad_sel = 1'b1;
                if (w_op_nxt == OP_WRITE) begin
                    w_wr_n   = 1'b0;
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_data_nxt;
                end else begin
                    // The RTC drives the bus, so output enable stays off.
                    w_rd_n   = 1'b0;
                end
            end
            default: begin
                w_cs_n = 1'b1;
            end
        endcase

        // Completion: the last DATA cycle produces the ack of the first
        // RECOV cycle and the ad_in sample for reads.
        w_rd_cap = (r_state == ST_DATA) & w_ph_last & (r_op == OP_READ);
        w_rd_ack = w_rd_cap;
        w_wr_ack = (r_state == ST_DATA) & w_ph_last & (r_op == OP_WRITE);
        w_busy   = (w_nxt_state != ST_IDLE);
    end

    // State register, phase counter and captured request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_op         <= OP_READ;
            r_addr       <= '0;
            r_data       <= '0;
            r_last_grant <= OP_READ;
        end else begin
            r_state <= w_nxt_state;
            if (w_nxt_state != r_state) begin
                r_cnt <= 4'd0;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
            r_op   <= w_op_nxt;
            r_addr <= w_addr_nxt;
            r_data <= w_data_nxt;
            if (w_grant) begin
                r_last_grant <= w_op_nxt;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    // Registered bus pins, acks, busy and read data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cs_n    <= 1'b1;
            o_rd_n    <= 1'b1;
            o_wr_n    <= 1'b1;
            o_ad_sel  <= 1'b0;
            o_ad_oe   <= 1'b0;
            o_ad_out  <= '0;
            o_rd_ack  <= 1'b0;
            o_wr_ack  <= 1'b0;
            o_busy    <= 1'b0;
            o_rd_data <= '0;
        end else begin
            o_cs_n   <= w_cs_n;
            o_rd_n   <= w_rd_n;
            o_wr_n   <= w_wr_n;
            o_ad_sel <= w_ad_sel;
            o_ad_oe  <= w_ad_oe;
            o_ad_out <= w_ad_out;
            o_rd_ack <= w_rd_ack;
            o_wr_ack <= w_wr_ack;
            o_busy   <= w_busy;
            if (w_rd_cap) begin
                o_rd_data <= i_ad_in;
            end else begin
                o_rd_data <= o_rd_data;
            end
        end
    end

endmodule
